// File: rtl/spi_pkg.sv
// SPI slave shared types and constants.
// Holds the receive FSM state encoding and default SPI settings.
package spi_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int CLK_DIV        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2
  } slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchroniser with rise/fall strobes.
// Ports: clk, rst (sync, active-low), d (async in), q, rise, fall.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled sclk/cs/mosi, parallel rx words, miso reply.
// Ports: clk, rst, sclk, cs, mosi, miso, tx_data, rx_data, rx_valid, frame_err, busy.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int SKIP_EDGES  = 1,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);
  localparam int SW = (SKIP_EDGES > 1) ? $clog2(SKIP_EDGES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [SW-1:0] SK_LAST =
    SW'((SKIP_EDGES > 0) ? SKIP_EDGES - 1 : 0);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_lvl_unused, cs_lvl_unused;
  logic mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs),
    .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  slv_state_t        state, state_d;
  logic [CW-1:0]     bit_cnt;
  logic [SW-1:0]     skip_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, rx_next, tx_next;
  logic load, skip_inc, take, word_done, word_err, tx_shift, to_idle;

  always_comb begin
    rx_next = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s}
                        : {mosi_s, rx_sr[DATA_W-1:1]};
    tx_next = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0}
                        : {1'b0, tx_sr[DATA_W-1:1]};
  end

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    skip_inc  = 1'b0;
    take      = 1'b0;
    word_done = 1'b0;
    word_err  = 1'b0;
    tx_shift  = 1'b0;
    // cs_fall outside IDLE cannot happen; treat it as a restart
    if (cs_fall) begin
      state_d = (SKIP_EDGES == 0) ? SHIFT : SKIP;
      load    = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        SKIP: begin
          if (cs_rise) begin
            state_d = IDLE;
          end else if (sclk_rise) begin
            if (skip_cnt == SK_LAST) state_d = SHIFT;
            else skip_inc = 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_d  = IDLE;
            word_err = (bit_cnt != '0);
          end else begin
            take      = sclk_rise;
            word_done = sclk_rise && (bit_cnt == LAST);
            // hold the freshly loaded word until its first bit is sampled
            tx_shift  = sclk_fall && (bit_cnt != '0);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    to_idle = (state != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      skip_cnt  <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= word_done;
      frame_err <= word_err;
      if (load) begin
        tx_sr    <= tx_data;
        bit_cnt  <= '0;
        skip_cnt <= '0;
      end
      if (skip_inc) skip_cnt <= skip_cnt + 1'b1;
      if (take) begin
        rx_sr   <= rx_next;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) begin
        rx_data <= rx_next;
        tx_sr   <= tx_data;
      end
      if (tx_shift) tx_sr <= tx_next;
      if (to_idle) begin
        bit_cnt  <= '0;
        skip_cnt <= '0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign miso = busy & (MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0]);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: BFM master, scoreboard on rx words and errors.
// Random frames modelled by whole-word/partial-word arithmetic.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  spi_slave_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;
  int got_err = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: pops the expected word whenever the DUT presents one
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        chk("err_with_valid", 32'(frame_err), 32'd0);
        if (exp_rx.size() == 0)
          chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        else
          chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (frame_err) got_err++;
    end
  end

  // one master frame: start pulse, nbits data bits, cs high, trailing pulse
  task automatic frame(input logic [15:0] data, input int nbits,
                       input logic [7:0] tx0, input logic [7:0] tx1,
                       input bit mid_rst);
    logic [7:0] cap;
    int nw;
    cap = 8'h00;
    nw = mid_rst ? 0 : nbits / 8;
    for (int w = 0; w < nw; w++)
      exp_rx.push_back(w == 0 ? data[15:8] : data[7:0]);
    if (!mid_rst && (nbits % 8) != 0) exp_err++;
    tx_data = tx0;
    cs = 1'b0;
    wclk(4);
    sclk = 1'b1;
    wclk(4);
    sclk = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[15-i];
      wclk(4);
      sclk = 1'b1;
      cap = {cap[6:0], miso};
      if (i == 2) tx_data = tx1;
      if (i == 7) chk("miso_w0", 32'(cap), 32'(tx0));
      if (i == 15) chk("miso_w1", 32'(cap), 32'(tx1));
      wclk(4);
      sclk = 1'b0;
      if (mid_rst && i == 3) begin
        rst = 1'b0;
        cs = 1'b1;
        wclk(4);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        rst = 1'b1;
        break;
      end
    end
    mosi = 1'b0;
    wclk(4);
    cs = 1'b1;
    wclk(2);
    sclk = 1'b1;
    wclk(4);
    sclk = 1'b0;
    wclk(12);
    if (mid_rst) last_rx = 8'h00;
    else if (nw == 2) last_rx = data[7:0];
    else if (nw == 1) last_rx = data[15:8];
    chk("miso_idle", 32'(miso), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rx_hold", 32'(rx_data), 32'(last_rx));
    chk("err_count", 32'(got_err), 32'(exp_err));
    chk("rx_drained", 32'(exp_rx.size()), 32'd0);
  endtask

  initial begin
    wclk(4);
    chk("rst_rx_data0", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_miso0", 32'(miso), 32'd0);
    rst = 1'b1;
    wclk(4);

    frame(16'hEB00, 8, 8'h5A, 8'h00, 1'b0);
    frame(16'h9800, 5, 8'h77, 8'h11, 1'b0);
    frame(16'h3CC3, 16, 8'($urandom), 8'($urandom), 1'b0);
    frame(16'h6600, 8, 8'h81, 8'h18, 1'b1);
    frame(16'hA500, 8, 8'hC7, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1;
      wclk(4);
      chk("cs_high_busy", 32'(busy), 32'd0);
      sclk = 1'b0;
      wclk(4);
    end
    wclk(8);
    chk("cs_high_err", 32'(got_err), 32'(exp_err));
    chk("cs_high_rx", 32'(rx_data), 32'(last_rx));

    for (int k = 0; k < 12; k++) begin
      int nb;
      nb = (k % 3 == 0) ? 16 : int'($urandom_range(1, 16));
      frame(16'($urandom), nb, 8'($urandom), 8'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
